// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: opcodes, immediate/result selects,
// control bundle and the buffered decode entry.
package riscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    IMM_I = 2'd0,
    IMM_J = 2'd1,
    IMM_U = 2'd2,
    IMM_B = 2'd3
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_src_e;

  typedef struct packed {
    logic        reg_write;
    logic        alu_src;
    logic        mem_write;
    result_src_e result_src;
    logic        branch;
    logic        jump;
    logic        illegal;
  } id_ctrl_t;

  typedef struct packed {
    id_ctrl_t    ctrl;
    imm_src_e    imm_src;
    logic [31:7] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        funct7b5;
  } id_entry_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// slave = the stage, master = its environment.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic            flush;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [31:7]     id_imm;
  logic [1:0]      id_imm_src;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic [2:0]      id_funct3;
  logic            id_funct7b5;
  logic            id_reg_write;
  logic            id_alu_src;
  logic            id_mem_write;
  logic [1:0]      id_result_src;
  logic            id_branch;
  logic            id_jump;
  logic            id_illegal;

  modport slave (
    input  if_valid, if_instr, if_pc, flush, id_ready,
    output if_ready, id_valid, id_pc, id_imm, id_imm_src,
    output id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5,
    output id_reg_write, id_alu_src, id_mem_write,
    output id_result_src, id_branch, id_jump, id_illegal
  );

  modport master (
    output if_valid, if_instr, if_pc, flush, id_ready,
    input  if_ready, id_valid, id_pc, id_imm, id_imm_src,
    input  id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5,
    input  id_reg_write, id_alu_src, id_mem_write,
    input  id_result_src, id_branch, id_jump, id_illegal
  );
endinterface

// File: rtl/instr_decoder.sv
// Combinational RV32I opcode decoder; stores are repacked so the
// extender can treat them as I-type.
module instr_decoder
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output id_ctrl_t    ctrl,
  output imm_src_e    imm_src,
  output logic [31:7] imm
);

  logic [6:0] op;
  assign op = instr[6:0];

  always_comb begin
    ctrl    = '0;
    imm_src = IMM_I;
    imm     = instr[31:7];
    unique case (1'b1)
      (op == OP_LUI) | (op == OP_AUIPC): begin
        imm_src        = IMM_U;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      op == OP_JAL: begin
        imm_src         = IMM_J;
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = RES_PC4;
      end
      op == OP_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_PC4;
      end
      op == OP_BRANCH: begin
        imm_src     = IMM_B;
        ctrl.branch = 1'b1;
      end
      op == OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
      end
      op == OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm = {instr[31:25], instr[11:7], instr[19:7]};
      end
      op == OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      op == OP_REG: begin
        ctrl.reg_write = 1'b1;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// IF/ID stage: decode at the input, then a main + skid elastic
// buffer so if_ready can come straight from a flop.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit ILLEGAL_DROP = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  decode_stage_if.slave  bus
);

  id_ctrl_t        dctrl;
  imm_src_e        dsrc;
  logic [31:7]     dimm;
  id_entry_t       in_e;
  id_entry_t       main_e;
  id_entry_t       skid_e;
  logic [XLEN-1:0] main_pc;
  logic [XLEN-1:0] skid_pc;
  logic            main_valid;
  logic            skid_valid;
  logic            accept;
  logic            enq;
  logic            advance;

  instr_decoder u_dec (
    .instr   (bus.if_instr),
    .ctrl    (dctrl),
    .imm_src (dsrc),
    .imm     (dimm)
  );

  always_comb begin
    in_e          = '0;
    in_e.ctrl     = dctrl;
    in_e.imm_src  = dsrc;
    in_e.imm      = dimm;
    in_e.rs1      = bus.if_instr[19:15];
    in_e.rs2      = bus.if_instr[24:20];
    in_e.rd       = bus.if_instr[11:7];
    in_e.funct3   = bus.if_instr[14:12];
    in_e.funct7b5 = bus.if_instr[30];
  end

  // A dropped illegal still completes the handshake.
  assign accept  = bus.if_valid & ~skid_valid & ~bus.flush;
  assign enq     = accept & ~(ILLEGAL_DROP & dctrl.illegal);
  assign advance = ~main_valid | bus.id_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_e     <= '0;
      skid_e     <= '0;
      main_pc    <= '0;
      skid_pc    <= '0;
    end else if (bus.flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (advance) begin
      if (skid_valid) begin
        main_e     <= skid_e;
        main_pc    <= skid_pc;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= enq;
        if (enq) begin
          main_e  <= in_e;
          main_pc <= bus.if_pc;
        end
      end
    end else if (enq) begin
      skid_e     <= in_e;
      skid_pc    <= bus.if_pc;
      skid_valid <= 1'b1;
    end
  end

  assign bus.if_ready      = ~skid_valid;
  assign bus.id_valid      = main_valid;
  assign bus.id_pc         = main_pc;
  assign bus.id_imm        = main_e.imm;
  assign bus.id_imm_src    = main_e.imm_src;
  assign bus.id_rs1        = main_e.rs1;
  assign bus.id_rs2        = main_e.rs2;
  assign bus.id_rd         = main_e.rd;
  assign bus.id_funct3     = main_e.funct3;
  assign bus.id_funct7b5   = main_e.funct7b5;
  assign bus.id_alu_src    = main_e.ctrl.alu_src;
  assign bus.id_result_src = main_e.ctrl.result_src;
  assign bus.id_reg_write  = main_e.ctrl.reg_write & main_valid;
  assign bus.id_mem_write  = main_e.ctrl.mem_write & main_valid;
  assign bus.id_branch     = main_e.ctrl.branch & main_valid;
  assign bus.id_jump       = main_e.ctrl.jump & main_valid;
  assign bus.id_illegal    = main_e.ctrl.illegal & main_valid;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: vector table, directed stall/flush/drop
// sequences and random traffic against a 2-deep queue model.
module tb_decode_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        v;
  logic        fl;
  logic        rdy;
  logic [31:0] ins;
  logic [31:0] pc;

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32)) ia ();
  decode_stage_if #(.XLEN(32)) ib ();

  assign ia.if_valid = v;
  assign ia.if_instr = ins;
  assign ia.if_pc    = pc;
  assign ia.flush    = fl;
  assign ia.id_ready = rdy;
  assign ib.if_valid = v;
  assign ib.if_instr = ins;
  assign ib.if_pc    = pc;
  assign ib.flush    = fl;
  assign ib.id_ready = rdy;

  decode_stage #(.XLEN(32), .ILLEGAL_DROP(1'b0)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia)
  );

  decode_stage #(.XLEN(32), .ILLEGAL_DROP(1'b1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  typedef struct packed {
    logic        rw;
    logic        alu;
    logic        mw;
    logic [1:0]  res;
    logic        br;
    logic        j;
    logic        ill;
    logic [1:0]  src;
    logic [24:0] imm;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } item_t;

  typedef struct {
    logic [31:0] ins;
    exp_t        e;
  } vec_t;

  int    tests = 0;
  int    fails = 0;
  item_t q[$];
  vec_t  tbl[10];

  function automatic exp_t mk(
    logic rw, logic alu, logic mw, logic [1:0] res,
    logic br, logic j, logic ill, logic [1:0] src,
    logic [24:0] imm
  );
    exp_t e;
    e = {rw, alu, mw, res, br, j, ill, src, imm};
    return e;
  endfunction

  // Reference decode straight from the opcode table.
  function automatic exp_t ref_dec(logic [31:0] i);
    exp_t e;
    e = '0;
    e.imm = i[31:7];
    case (i[6:0])
      7'h37, 7'h17: begin e.src = 2; e.rw = 1; e.alu = 1; end
      7'h6F: begin e.src = 1; e.rw = 1; e.j = 1; e.res = 2; end
      7'h67: begin e.rw = 1; e.j = 1; e.alu = 1; e.res = 2; end
      7'h63: begin e.src = 3; e.br = 1; end
      7'h03: begin e.rw = 1; e.alu = 1; e.res = 1; end
      7'h23: begin
        e.mw = 1;
        e.alu = 1;
        e.imm = {i[31:25], i[11:7], i[19:7]};
      end
      7'h13: begin e.rw = 1; e.alu = 1; end
      7'h33: e.rw = 1;
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  function automatic exp_t got_a();
    return mk(ia.id_reg_write, ia.id_alu_src, ia.id_mem_write,
              ia.id_result_src, ia.id_branch, ia.id_jump,
              ia.id_illegal, ia.id_imm_src, ia.id_imm);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: the model pops/pushes, then dut_a is compared to it.
  task automatic cycle();
    logic  acc;
    exp_t  e;
    item_t h;
    acc = v & (q.size() < 2) & ~fl;
    @(posedge clk);
    #1;
    if (rst || fl) begin
      q.delete();
    end else begin
      if (rdy && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back('{ins: ins, pc: pc});
    end
    chk("if_ready", ia.if_ready, q.size() < 2);
    chk("id_valid", ia.id_valid, q.size() > 0);
    if (q.size() > 0) begin
      h = q[0];
      e = ref_dec(h.ins);
      chk("decode", got_a(), e);
      chk("id_pc", ia.id_pc, h.pc);
      chk("fields",
          {ia.id_rs1, ia.id_rs2, ia.id_rd, ia.id_funct3, ia.id_funct7b5},
          {h.ins[19:15], h.ins[24:20], h.ins[11:7], h.ins[14:12], h.ins[30]});
    end else begin
      chk("idle_en",
          {ia.id_reg_write, ia.id_mem_write, ia.id_branch,
           ia.id_jump, ia.id_illegal}, 5'b0);
    end
  endtask

  logic [6:0] ops[10];

  initial begin
    tbl[0] = '{32'h00500093, mk(1,1,0,0,0,0,0,0,25'h000A001)};
    tbl[1] = '{32'h0020A423, mk(0,1,1,0,0,0,0,0,25'h0010148)};
    tbl[2] = '{32'h008000EF, mk(1,0,0,2,0,1,0,1,25'h0010001)};
    tbl[3] = '{32'hFFFFFFFF, mk(0,0,0,0,0,0,1,0,25'h1FFFFFF)};
    tbl[4] = '{32'h123452B7, mk(1,1,0,0,0,0,0,2,25'h02468A5)};
    tbl[5] = '{32'h00208463, mk(0,0,0,0,1,0,0,3,25'h0004108)};
    tbl[6] = '{32'h0040A183, mk(1,1,0,1,0,0,0,0,25'h0008143)};
    tbl[7] = '{32'h002081B3, mk(1,0,0,0,0,0,0,0,25'h0004103)};
    tbl[8] = '{32'h00008067, mk(1,1,0,2,0,1,0,0,25'h0000100)};
    tbl[9] = '{32'h00001097, mk(1,1,0,0,0,0,0,2,25'h0000021)};
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
            7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};

    rst = 1; v = 0; fl = 0; rdy = 0; ins = 0; pc = 0;
    cycle();
    cycle();
    chk("rst_imm", ia.id_imm, 0);
    chk("rst_pc", ia.id_pc, 0);
    chk("rst_misc",
        {ia.id_rd, ia.id_rs1, ia.id_rs2, ia.id_imm_src,
         ia.id_alu_src, ia.id_result_src}, 0);
    rst = 0;

    rdy = 1;
    for (int i = 0; i < 10; i++) begin
      v   = 1;
      ins = tbl[i].ins;
      pc  = 32'h100 + 32'(4 * i);
      cycle();
      chk("tbl_decode", got_a(), tbl[i].e);
      chk("tbl_pc", ia.id_pc, pc);
      if (i == 0) chk("addi_rd", ia.id_rd, 5'd1);
      if (i == 1) chk("sw_rs", {ia.id_rs1, ia.id_rs2}, {5'd1, 5'd2});
    end
    v = 0;
    cycle();

    rdy = 0; v = 1;
    ins = 32'h00100093; pc = 32'h200; cycle();
    ins = 32'h00200113; pc = 32'h204; cycle();
    ins = 32'h00300193; pc = 32'h208; cycle();
    chk("stall_head", ia.id_pc, 32'h200);
    chk("stall_rdy", ia.if_ready, 1'b0);
    rdy = 1;
    cycle();
    chk("drain_b", ia.id_pc, 32'h204);
    cycle();
    chk("drain_c", ia.id_pc, 32'h208);
    v = 0;
    cycle();
    chk("drain_empty", ia.id_valid, 1'b0);

    rdy = 0; v = 1;
    ins = 32'h00100093; pc = 32'h300; cycle();
    ins = 32'h00200113; pc = 32'h304; cycle();
    ins = 32'h00300193; pc = 32'h308; fl = 1; cycle();
    chk("flush_valid", ia.id_valid, 1'b0);
    chk("flush_rdy", ia.if_ready, 1'b1);
    fl = 0; v = 0;
    cycle();
    chk("flush_gone", ia.id_valid, 1'b0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] r;
      r   = $urandom();
      ins = {r[31:7], ops[$urandom_range(0, 9)]};
      pc  = $urandom() & 32'hFFFF_FFFC;
      v   = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 6);
      fl  = ($urandom_range(0, 15) == 0);
      cycle();
    end

    fl = 1; v = 0; rdy = 1;
    cycle();
    fl = 0; v = 1;
    ins = 32'hFFFFFFFF; pc = 32'h400;
    cycle();
    chk("drop_valid", ib.id_valid, 1'b0);
    chk("drop_rdy", ib.if_ready, 1'b1);
    chk("fwd_illegal", ia.id_illegal, 1'b1);
    ins = 32'h00500093; pc = 32'h500;
    cycle();
    chk("drop_next_v", ib.id_valid, 1'b1);
    chk("drop_next_pc", ib.id_pc, 32'h500);
    chk("drop_next_ill", ib.id_illegal, 1'b0);
    v = 0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
